// File: rtl/oam_dma_controller_if.sv
// CPU-side and memory-side bus bundle for the sprite-DMA sequencer.
// The master modport is the DMA controller; the slave modport is the CPU/memory environment.
interface oam_dma_controller_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_rw;
  logic        cpu_rdy;
  logic [7:0]  cpu_data_in;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rw;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        done;

  modport master (
    input  cpu_addr, cpu_data_out, cpu_rw, mem_rdata,
    output cpu_rdy, cpu_data_in, mem_addr, mem_wdata, mem_rw, busy, done
  );

  modport slave (
    output cpu_addr, cpu_data_out, cpu_rw, mem_rdata,
    input  cpu_rdy, cpu_data_in, mem_addr, mem_wdata, mem_rw, busy, done
  );
endinterface

// File: rtl/oam_dma_controller.sv
// Sprite-DMA sequencer: stalls the CPU and copies a source page to the OAM data port
// with get/put cycle alignment; otherwise passes the CPU bus straight through.
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input logic                   clk,
  input logic                   rst,
  oam_dma_controller_if.master  bus
);

  localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {StIdle, StHalt, StAlign, StRead, StWrite} state_e;

  state_e     state_q, state_d;
  logic       cycle_odd_q;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] data_buf_q, data_buf_d;
  logic       done_q, done_d;

  logic [15:0] mem_addr_c;
  logic [7:0]  mem_wdata_c;
  logic        mem_rw_c;
  logic        cpu_rdy_c;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    page_d      = page_q;
    data_buf_d  = data_buf_q;
    done_d      = 1'b0;
    mem_addr_c  = bus.cpu_addr;
    mem_wdata_c = bus.cpu_data_out;
    mem_rw_c    = bus.cpu_rw;
    cpu_rdy_c   = 1'b1;

    unique case (state_q)
      StIdle: begin
        // The trigger write itself still reaches the bus via pass-through.
        if (!bus.cpu_rw && (bus.cpu_addr == DMA_REG_ADDR)) begin
          page_d  = bus.cpu_data_out;
          idx_d   = 8'h00;
          state_d = StHalt;
        end
      end
      StHalt, StAlign: begin
        cpu_rdy_c   = 1'b0;
        mem_rw_c    = 1'b1;
        mem_addr_c  = {page_q, 8'h00};
        mem_wdata_c = 8'h00;
        // An odd halt cycle means the next one is even, so reads can start now.
        if (state_q == StAlign || cycle_odd_q) begin
          state_d = StRead;
        end else begin
          state_d = StAlign;
        end
      end
      StRead: begin
        cpu_rdy_c   = 1'b0;
        mem_rw_c    = 1'b1;
        mem_addr_c  = {page_q, idx_q};
        mem_wdata_c = 8'h00;
        data_buf_d  = bus.mem_rdata;
        state_d     = StWrite;
      end
      StWrite: begin
        cpu_rdy_c   = 1'b0;
        mem_rw_c    = 1'b0;
        mem_addr_c  = OAM_DATA_ADDR;
        mem_wdata_c = data_buf_q;
        idx_d       = idx_q + 8'd1;
        if (idx_q == LastIdx) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cycle_odd_q <= 1'b0;
      idx_q       <= 8'h00;
      page_q      <= 8'h00;
      data_buf_q  <= 8'h00;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_odd_q <= ~cycle_odd_q;
      idx_q       <= idx_d;
      page_q      <= page_d;
      data_buf_q  <= data_buf_d;
      done_q      <= done_d;
    end
  end

  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_wdata   = mem_wdata_c;
  assign bus.mem_rw      = mem_rw_c;
  assign bus.cpu_rdy     = cpu_rdy_c;
  assign bus.cpu_data_in = bus.mem_rdata;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;

endmodule
